// File: rtl/vdp_vram_arbiter.sv
// Shares the single VRAM port between the screen renderer, CPU port and command
// engine; one outstanding transaction at a time, reads bounded by a timeout.
module vdp_vram_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        initial_busy,
    input  logic [16:0] scr_address,
    input  logic        scr_valid,
    output logic        scr_ready,
    output logic [31:0] scr_rdata,
    output logic        scr_rdata_en,
    input  logic [16:0] cpu_address,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rdata_en,
    input  logic [16:0] cmd_address,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_wdata,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [31:0] cmd_rdata,
    output logic        cmd_rdata_en,
    output logic [16:0] vram_address,
    output logic        vram_write,
    output logic        vram_valid,
    output logic [7:0]  vram_wdata,
    input  logic [31:0] vram_rdata,
    input  logic        vram_rdata_en,
    output logic        timeout_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_READ_WAIT} state_t;
    typedef enum logic [1:0] {OWN_SCR, OWN_CPU, OWN_CMD} owner_t;
    typedef struct packed {
        logic [16:0] address;
        logic        write;
        logic [7:0]  wdata;
    } vram_req_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t    state_q, state_d;
    owner_t    owner_q, owner_d;
    vram_req_t req_q, req_d;
    logic      prefer_cmd_q, prefer_cmd_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] rdata_en_q, rdata_en_d;
    logic [31:0] scr_rdata_q, scr_rdata_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] cmd_rdata_q, cmd_rdata_d;
    logic      timeout_err_q, timeout_err_d;
    logic      rd_done;
    logic [31:0] rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_SCR;
            req_q         <= '0;
            prefer_cmd_q  <= 1'b0;
            cnt_q         <= 8'd0;
            rdata_en_q    <= 3'b000;
            scr_rdata_q   <= 32'h0;
            cpu_rdata_q   <= 32'h0;
            cmd_rdata_q   <= 32'h0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            req_q         <= req_d;
            prefer_cmd_q  <= prefer_cmd_d;
            cnt_q         <= cnt_d;
            rdata_en_q    <= rdata_en_d;
            scr_rdata_q   <= scr_rdata_d;
            cpu_rdata_q   <= cpu_rdata_d;
            cmd_rdata_q   <= cmd_rdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        req_d         = req_q;
        prefer_cmd_d  = prefer_cmd_q;
        cnt_d         = cnt_q;
        rdata_en_d    = 3'b000;
        scr_rdata_d   = scr_rdata_q;
        cpu_rdata_d   = cpu_rdata_q;
        cmd_rdata_d   = cmd_rdata_q;
        timeout_err_d = 1'b0;
        rd_done       = 1'b0;
        rd_data       = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (!initial_busy && (scr_valid || cpu_valid || cmd_valid)) begin
                    state_d = ST_ISSUE;
                    if (scr_valid) begin
                        owner_d = OWN_SCR;
                        req_d   = '{address: scr_address, write: 1'b0, wdata: 8'h00};
                    end else if (cpu_valid && (!cmd_valid || !prefer_cmd_q)) begin
                        owner_d      = OWN_CPU;
                        req_d        = '{address: cpu_address, write: cpu_write, wdata: cpu_wdata};
                        prefer_cmd_d = 1'b1;
                    end else begin
                        owner_d      = OWN_CMD;
                        req_d        = '{address: cmd_address, write: cmd_write, wdata: cmd_wdata};
                        prefer_cmd_d = 1'b0;
                    end
                end
            end
            ST_ISSUE: begin
                if (req_q.write) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_READ_WAIT;
                    cnt_d   = 8'd0;
                end
            end
            ST_READ_WAIT: begin
                // Data arriving on the timeout cycle itself takes precedence.
                if (vram_rdata_en) begin
                    rd_done = 1'b1;
                    rd_data = vram_rdata;
                end else if (cnt_q == TIMEOUT_C) begin
                    rd_done       = 1'b1;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rd_done) begin
            state_d = ST_IDLE;
            case (owner_q)
                OWN_SCR: begin scr_rdata_d = rd_data; rdata_en_d[0] = 1'b1; end
                OWN_CPU: begin cpu_rdata_d = rd_data; rdata_en_d[1] = 1'b1; end
                OWN_CMD: begin cmd_rdata_d = rd_data; rdata_en_d[2] = 1'b1; end
                default: ;
            endcase
        end
    end

    assign vram_valid   = (state_q == ST_ISSUE);
    assign vram_address = req_q.address;
    assign vram_write   = req_q.write;
    assign vram_wdata   = req_q.wdata;
    assign scr_ready    = vram_valid && (owner_q == OWN_SCR);
    assign cpu_ready    = vram_valid && (owner_q == OWN_CPU);
    assign cmd_ready    = vram_valid && (owner_q == OWN_CMD);
    assign scr_rdata    = scr_rdata_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign cmd_rdata    = cmd_rdata_q;
    assign scr_rdata_en = rdata_en_q[0];
    assign cpu_rdata_en = rdata_en_q[1];
    assign cmd_rdata_en = rdata_en_q[2];
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Scoreboard bench for vdp_vram_arbiter: directed requests push expected grants
// and read returns; a negedge monitor pops and compares them.
module tb_vdp_vram_arbiter;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset, initial_busy;
    logic [16:0] scr_address, cpu_address, cmd_address;
    logic        scr_valid, cpu_valid, cmd_valid;
    logic        cpu_write, cmd_write;
    logic [7:0]  cpu_wdata, cmd_wdata;
    logic        scr_ready, cpu_ready, cmd_ready;
    logic [31:0] scr_rdata, cpu_rdata, cmd_rdata;
    logic        scr_rdata_en, cpu_rdata_en, cmd_rdata_en;
    logic [16:0] vram_address;
    logic        vram_write, vram_valid;
    logic [7:0]  vram_wdata;
    logic [31:0] vram_rdata;
    logic        vram_rdata_en;
    logic        timeout_err;

    vdp_vram_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .initial_busy(initial_busy),
        .scr_address(scr_address), .scr_valid(scr_valid), .scr_ready(scr_ready),
        .scr_rdata(scr_rdata), .scr_rdata_en(scr_rdata_en),
        .cpu_address(cpu_address), .cpu_write(cpu_write), .cpu_wdata(cpu_wdata),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .cpu_rdata_en(cpu_rdata_en),
        .cmd_address(cmd_address), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rdata(cmd_rdata),
        .cmd_rdata_en(cmd_rdata_en),
        .vram_address(vram_address), .vram_write(vram_write), .vram_valid(vram_valid),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .vram_rdata_en(vram_rdata_en),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          who;
        logic [16:0] a;
        logic        w;
        logic [7:0]  d;
    } gnt_t;
    typedef struct {
        int          who;
        logic [31:0] data;
        logic        terr;
        bit          is_to;
    } rd_t;

    gnt_t exp_g[$];
    rd_t  exp_r[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   gnt_cyc = 0;
    int   vr_cyc = 0;
    int   vlat = 3;

    always @(posedge clk) cyc <= cyc + 1;

    // VRAM contents: 0x00104 holds DEADBEEF, all other words encode their address.
    function automatic logic [31:0] word(input logic [16:0] a);
        if (a[16:2] == 15'h0041) return 32'hDEADBEEF;
        return {a[16:2], 2'b01, ~a[16:2]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic push_g(input int who, input logic [16:0] a, input logic w, input logic [7:0] d);
        gnt_t g;
        g.who = who; g.a = a; g.w = w; g.d = d;
        exp_g.push_back(g);
    endtask

    task automatic push_r(input int who, input logic [31:0] data, input logic terr, input bit is_to);
        rd_t r;
        r.who = who; r.data = data; r.terr = terr; r.is_to = is_to;
        exp_r.push_back(r);
    endtask

    // VRAM model: vlat cycles after the strobe, one-cycle data pulse; vlat=0 never answers.
    initial begin
        logic [16:0] a;
        int l;
        vram_rdata = 32'h0;
        vram_rdata_en = 1'b0;
        forever begin
            @(negedge clk);
            if (vram_valid && !vram_write && vlat > 0) begin
                a = vram_address;
                l = vlat;
                repeat (l) @(posedge clk);
                #1;
                vram_rdata = word(a);
                vram_rdata_en = 1'b1;
                vr_cyc = cyc;
                @(posedge clk);
                #1;
                vram_rdata_en = 1'b0;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        logic [2:0] rv, ev;
        int wact, lat;
        gnt_t g;
        rd_t r;
        logic [31:0] dact;
        if (!reset) begin
            rv = {cmd_ready, cpu_ready, scr_ready};
            ev = {cmd_rdata_en, cpu_rdata_en, scr_rdata_en};
            if (vram_valid) begin
                if (exp_g.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_grant: got strobe addr %h ready %b, required none", vram_address, rv);
                end else begin
                    g = exp_g.pop_front();
                    wact = (rv == 3'b001) ? 0 : (rv == 3'b010) ? 1 : (rv == 3'b100) ? 2 : 9;
                    chk("grant_owner", wact, g.who);
                    chk("grant_addr", {15'h0, vram_address}, {15'h0, g.a});
                    chk("grant_write", {31'h0, vram_write}, {31'h0, g.w});
                    if (g.w) chk("grant_wdata", {24'h0, vram_wdata}, {24'h0, g.d});
                end
                gnt_cyc = cyc;
            end else if (rv != 3'b000) begin
                chk("ready_without_strobe", {29'h0, rv}, 32'h0);
            end
            if (ev != 3'b000) begin
                if (exp_r.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_rdata_en: got en %b, required none", ev);
                end else begin
                    r = exp_r.pop_front();
                    wact = (ev == 3'b001) ? 0 : (ev == 3'b010) ? 1 : (ev == 3'b100) ? 2 : 9;
                    dact = (r.who == 0) ? scr_rdata : (r.who == 1) ? cpu_rdata : cmd_rdata;
                    chk("rd_owner", wact, r.who);
                    chk("rd_data", dact, r.data);
                    chk("rd_timeout_err", {31'h0, timeout_err}, {31'h0, r.terr});
                    if (r.is_to) begin
                        lat = cyc - gnt_cyc;
                        n_chk++;
                        if (lat < TO + 1 || lat > TO + 2) begin
                            n_err++;
                            $display("FAIL timeout_latency: got %0d cycles after strobe, required %0d..%0d", lat, TO + 1, TO + 2);
                        end
                    end else begin
                        chk("rd_latency", cyc, vr_cyc + 1);
                    end
                end
            end else if (timeout_err) begin
                chk("stray_timeout_err", 1, 0);
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vram_valid"}, {31'h0, vram_valid}, 0);
        chk({tag, "_vram_write"}, {31'h0, vram_write}, 0);
        chk({tag, "_vram_address"}, {15'h0, vram_address}, 0);
        chk({tag, "_vram_wdata"}, {24'h0, vram_wdata}, 0);
        chk({tag, "_readys"}, {29'h0, scr_ready, cpu_ready, cmd_ready}, 0);
        chk({tag, "_rdata_ens"}, {29'h0, scr_rdata_en, cpu_rdata_en, cmd_rdata_en}, 0);
        chk({tag, "_timeout_err"}, {31'h0, timeout_err}, 0);
        chk({tag, "_scr_rdata"}, scr_rdata, 0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
        chk({tag, "_cmd_rdata"}, cmd_rdata, 0);
    endtask

    task automatic wait_ready(input int who);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = (who == 0) ? scr_ready : (who == 1) ? cpu_ready : cmd_ready;
        end
        n_chk++;
        if (!got) begin
            n_err++;
            $display("FAIL ready_timeout: requester %0d got no ready, required a ready pulse", who);
        end
    endtask

    task automatic do_req(input int who, input logic [16:0] a, input logic w, input logic [7:0] d);
        push_g(who, a, w, d);
        @(posedge clk);
        #1;
        case (who)
            0: begin scr_address = a; scr_valid = 1'b1; end
            1: begin cpu_address = a; cpu_write = w; cpu_wdata = d; cpu_valid = 1'b1; end
            default: begin cmd_address = a; cmd_write = w; cmd_wdata = d; cmd_valid = 1'b1; end
        endcase
        wait_ready(who);
        @(posedge clk);
        #1;
        scr_valid = 1'b0; cpu_valid = 1'b0; cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_r.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("read_returned", exp_r.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err + 1);
        $fatal(1);
    end

    initial begin
        int seen, ng, k;
        bit scr_sent, s_r, c_r;
        reset = 1'b1; initial_busy = 1'b1;
        scr_address = '0; cpu_address = '0; cmd_address = '0;
        scr_valid = 1'b0; cpu_valid = 1'b0; cmd_valid = 1'b0;
        cpu_write = 1'b0; cmd_write = 1'b0; cpu_wdata = '0; cmd_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst");

        // CPU write held while VRAM is busy
        cpu_address = 17'h1_0003; cpu_write = 1'b1; cpu_wdata = 8'h5A; cpu_valid = 1'b1;
        push_g(1, 17'h1_0003, 1'b1, 8'h5A);
        seen = 0;
        repeat (1000) begin
            @(negedge clk);
            if (vram_valid) seen++;
        end
        chk("busy_blocks_grant", seen, 0);
        @(posedge clk);
        #1 initial_busy = 1'b0;
        @(negedge clk);
        chk("strobe_not_same_cycle", {31'h0, vram_valid}, 0);
        @(negedge clk);
        chk("strobe_next_cycle", {31'h0, vram_valid}, 1);
        chk("strobe_write", {31'h0, vram_write}, 1);
        chk("strobe_cpu_ready", {31'h0, cpu_ready}, 1);
        @(posedge clk);
        #1 cpu_valid = 1'b0; cpu_write = 1'b0;
        repeat (4) @(negedge clk);

        // cmd write hands round-robin preference back to CPU
        do_req(2, 17'h0_0ABC, 1'b1, 8'hC3);

        // screen read, 3-cycle VRAM latency
        vlat = 3;
        push_r(0, 32'hDEADBEEF, 1'b0, 1'b0);
        do_req(0, 17'h0_0104, 1'b0, 8'h00);
        drain();
        chk("cpu_rdata_untouched", cpu_rdata, 32'h0);

        // CPU and cmd reading continuously, one screen pulse
        vlat = 2;
        push_g(1, 17'h0_0200, 1'b0, 8'h00); push_r(1, word(17'h0_0200), 1'b0, 1'b0);
        push_g(2, 17'h0_0300, 1'b0, 8'h00); push_r(2, word(17'h0_0300), 1'b0, 1'b0);
        push_g(0, 17'h0_0404, 1'b0, 8'h00); push_r(0, word(17'h0_0404), 1'b0, 1'b0);
        push_g(1, 17'h0_0200, 1'b0, 8'h00); push_r(1, word(17'h0_0200), 1'b0, 1'b0);
        push_g(2, 17'h0_0300, 1'b0, 8'h00); push_r(2, word(17'h0_0300), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        cpu_address = 17'h0_0200; cpu_write = 1'b0; cpu_valid = 1'b1;
        cmd_address = 17'h0_0300; cmd_write = 1'b0; cmd_valid = 1'b1;
        scr_address = 17'h0_0404;
        ng = 0; k = 0; scr_sent = 1'b0;
        while (ng < 5 && k < 300) begin
            @(negedge clk);
            k++;
            if (scr_ready || cpu_ready || cmd_ready) begin
                ng++;
                s_r = scr_ready; c_r = cmd_ready;
                @(posedge clk);
                #1;
                if (s_r) scr_valid = 1'b0;
                if (c_r && !scr_sent) begin scr_valid = 1'b1; scr_sent = 1'b1; end
                if (ng == 5) begin cpu_valid = 1'b0; cmd_valid = 1'b0; end
            end
        end
        chk("round_robin_grants", ng, 5);
        cpu_valid = 1'b0; cmd_valid = 1'b0; scr_valid = 1'b0;
        drain();
        chk("scr_rdata_holds", scr_rdata, word(17'h0_0404));

        // VRAM never answers: timeout with zero data
        vlat = 0;
        push_r(2, 32'h0, 1'b1, 1'b1);
        do_req(2, 17'h0_0508, 1'b0, 8'h00);
        drain();

        // next read granted normally; data lands exactly on the timeout cycle
        vlat = TO + 1;
        push_r(1, word(17'h0_060C), 1'b0, 1'b0);
        do_req(1, 17'h0_060C, 1'b0, 8'h00);
        drain();

        // reset while waiting on a read; the late data must be ignored
        vlat = 10;
        do_req(1, 17'h0_0700, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        repeat (15) @(negedge clk);
        push_g(1, 17'h0_0800, 1'b1, 8'h11);
        push_g(2, 17'h0_0900, 1'b1, 8'h22);
        @(posedge clk);
        #1;
        cpu_address = 17'h0_0800; cpu_write = 1'b1; cpu_wdata = 8'h11; cpu_valid = 1'b1;
        cmd_address = 17'h0_0900; cmd_write = 1'b1; cmd_wdata = 8'h22; cmd_valid = 1'b1;
        wait_ready(1);
        @(posedge clk);
        #1 cpu_valid = 1'b0;
        wait_ready(2);
        @(posedge clk);
        #1 cmd_valid = 1'b0;

        repeat (10) @(negedge clk);
        chk("grant_queue_empty", exp_g.size(), 0);
        chk("read_queue_empty", exp_r.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
